profile_ci_dispatch: RTL and testbench

PROFILE_CI_DISPATCH -- requirements
Module: profile_ci_dispatch

---
 rtl/profile_ci_dispatch_if.sv | 27 ++
 rtl/profile_ci_dispatch.sv | 94 +++++++++
 tb/tb_profile_ci_dispatch.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/profile_ci_dispatch_if.sv
// Bundle of CPU custom-instruction signals and the four-slave fan-out
// handled by profile_ci_dispatch.
interface profile_ci_dispatch_if;
    logic         start;
    logic [7:0]   ciN;
    logic [31:0]  valueA;
    logic [31:0]  valueB;
    logic         done;
    logic [31:0]  result;
    logic [3:0]   slaveStart;
    logic [31:0]  slaveValueA;
    logic [31:0]  slaveValueB;
    logic [3:0]   slaveDone;
    logic [127:0] slaveResult;
    logic         timeoutFlag;

    // The dispatcher itself sits on the slave side of this bundle.
    modport slave (
        input  start, ciN, valueA, valueB, slaveDone, slaveResult,
        output done, result, slaveStart, slaveValueA, slaveValueB, timeoutFlag
    );

    modport master (
        output start, ciN, valueA, valueB, slaveDone, slaveResult,
        input  done, result, slaveStart, slaveValueA, slaveValueB, timeoutFlag
    );
endinterface

// File: rtl/profile_ci_dispatch.sv
// Routes a CPU custom instruction to one of four slaves by ID, waits for the
// target's done (bounded by TIMEOUT) and returns its result as a one-cycle pulse.
module profile_ci_dispatch #(
    parameter logic [7:0]  ID0     = 8'h00,
    parameter logic [7:0]  ID1     = 8'h01,
    parameter logic [7:0]  ID2     = 8'h02,
    parameter logic [7:0]  ID3     = 8'h03,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                  clock,
    input logic                  reset,
    profile_ci_dispatch_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

    state_t      state;
    logic [1:0]  target;
    logic [15:0] wait_cnt;

    logic        hit;
    logic [1:0]  hit_idx;
    logic        tgt_done;
    logic [31:0] tgt_result;

    // Lowest matching index wins when several IDs are equal.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit     = 1'b1;
        hit_idx = 2'd0;
        if (bus.ciN == ID0)      hit_idx = 2'd0;
        else if (bus.ciN == ID1) hit_idx = 2'd1;
        else if (bus.ciN == ID2) hit_idx = 2'd2;
        else if (bus.ciN == ID3) hit_idx = 2'd3;
        else                     hit     = 1'b0;
    end

    assign tgt_done   = bus.slaveDone[target];
    assign tgt_result = bus.slaveResult[{target, 5'd0} +: 32];

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            target          <= 2'd0;
            wait_cnt        <= '0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.slaveStart  <= '0;
            bus.slaveValueA <= '0;
            bus.slaveValueB <= '0;
            bus.timeoutFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && hit) begin
                        state           <= WAIT;
                        target          <= hit_idx;
                        wait_cnt        <= '0;
                        bus.slaveStart  <= 4'b0001 << hit_idx;
                        bus.slaveValueA <= bus.valueA;
                        bus.slaveValueB <= bus.valueB;
                    end
                end
                WAIT: begin
                    bus.slaveStart <= '0;
                    // A target done in the timeout cycle still delivers its real result.
                    if (tgt_done) begin
                        bus.result <= tgt_result;
                        bus.done   <= 1'b1;
                        state      <= RESP;
                    end else if (({1'b0, wait_cnt} + 17'd1) == TIMEOUT_L) begin
                        wait_cnt        <= wait_cnt + 16'd1;
                        bus.result      <= 32'hFFFF_FFFF;
                        bus.timeoutFlag <= 1'b1;
                        bus.done        <= 1'b1;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    bus.done   <= 1'b0;
                    bus.result <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_profile_ci_dispatch.sv
// Scoreboard bench for profile_ci_dispatch: a default-parameter instance and
// one with aliased IDs and a short timeout.
module tb_profile_ci_dispatch;

    typedef struct {
        logic [31:0] res;
        int unsigned at;
    } exp_t;

    logic        clock;
    logic        reset;
    int unsigned cyc;
    int          n_cmp;
    int          n_bad;
    exp_t        q0[$];
    exp_t        q1[$];

    profile_ci_dispatch_if if0();
    profile_ci_dispatch_if if1();

    profile_ci_dispatch dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    profile_ci_dispatch #(
        .ID0     (8'h05),
        .ID1     (8'h05),
        .ID2     (8'h02),
        .ID3     (8'h03),
        .TIMEOUT (4)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each done pulse is matched against the oldest expected result and cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (if0.done) begin
                if (q0.size() == 0) check("dut0_extra_done", 32'(if0.done), 32'h0);
                else begin
                    e = q0.pop_front();
                    check("dut0_result", if0.result, e.res);
                    check("dut0_done_cycle", cyc, e.at);
                end
            end else check("dut0_idle_result", if0.result, 32'h0);
            if (if1.done) begin
                if (q1.size() == 0) check("dut1_extra_done", 32'(if1.done), 32'h0);
                else begin
                    e = q1.pop_front();
                    check("dut1_result", if1.result, e.res);
                    check("dut1_done_cycle", cyc, e.at);
                end
            end else check("dut1_idle_result", if1.result, 32'h0);
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        {if0.start, if0.ciN, if0.valueA, if0.valueB, if0.slaveDone, if0.slaveResult} = '0;
        {if1.start, if1.ciN, if1.valueA, if1.valueB, if1.slaveDone, if1.slaveResult} = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #7;
        check("rst_done",   32'(if0.done), 32'h0);
        check("rst_result", if0.result, 32'h0);
        check("rst_sstart", 32'(if0.slaveStart), 32'h0);
        check("rst_sva",    if0.slaveValueA, 32'h0);
        check("rst_svb",    if0.slaveValueB, 32'h0);
        check("rst_tflag",  32'(if1.timeoutFlag), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Combinational slave 1: done two cycles after start, one cycle wide.
        if0.slaveDone = 4'b0010;
        if0.slaveResult[63:32] = 32'h1234;
        if0.valueA = 32'd2;
        if0.valueB = 32'd3;
        if0.ciN = 8'h01;
        if0.start = 1'b1;
        q0.push_back('{res: 32'h1234, at: cyc + 2});
        @(negedge clock);
        if0.start = 1'b0;
        check("t1_sstart", 32'(if0.slaveStart), 32'h2);
        check("t1_sva", if0.slaveValueA, 32'd2);
        check("t1_svb", if0.slaveValueB, 32'd3);
        @(negedge clock);
        @(negedge clock);
        check("t1_done_one_cycle", 32'(if0.done), 32'h0);
        if0.slaveDone = 4'b0000;
        @(negedge clock);

        // Slave 2 answers five cycles after its start; stray start and slave-0 done ignored.
        if0.slaveResult = {32'h0, 32'hCAFE, 32'h0, 32'hDEAD};
        if0.valueA = 32'hA5A5_0001;
        if0.valueB = 32'h5A5A_0002;
        if0.ciN = 8'h02;
        if0.start = 1'b1;
        q0.push_back('{res: 32'hCAFE, at: cyc + 7});
        @(negedge clock);
        if0.start = 1'b0;
        check("t2_sstart", 32'(if0.slaveStart), 32'h4);
        @(negedge clock);
        if0.start = 1'b1;
        if0.ciN = 8'h00;
        if0.valueA = 32'hFFFF_FFFF;
        if0.valueB = 32'hFFFF_FFFF;
        if0.slaveDone = 4'b0001;
        @(negedge clock);
        if0.start = 1'b0;
        if0.slaveDone = 4'b0000;
        for (int i = 3; i <= 6; i++) begin
            if (i > 3) @(negedge clock);
            check("t2_sva_hold", if0.slaveValueA, 32'hA5A5_0001);
            check("t2_svb_hold", if0.slaveValueB, 32'h5A5A_0002);
            check("t2_sstart_low", 32'(if0.slaveStart), 32'h0);
            if (i == 6) if0.slaveDone = 4'b0100;
        end
        @(negedge clock);
        if0.slaveDone = 4'b0000;
        @(negedge clock);

        // Target done in the very cycle the counter reaches TIMEOUT wins.
        if1.slaveResult = {32'hBEEF, 32'h0, 32'h0, 32'h0};
        if1.ciN = 8'h03;
        if1.start = 1'b1;
        q1.push_back('{res: 32'hBEEF, at: cyc + 5});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if1.start = 1'b0;
            if (i == 4) if1.slaveDone = 4'b1000;
        end
        @(negedge clock);
        if1.slaveDone = 4'b0000;
        check("t3_tflag_clear", 32'(if1.timeoutFlag), 32'h0);
        @(negedge clock);

        // Stuck slave 3 times out after four WAIT cycles.
        if1.start = 1'b1;
        q1.push_back('{res: 32'hFFFF_FFFF, at: cyc + 5});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if1.start = 1'b0;
            if (i == 4) check("t4_tflag_not_early", 32'(if1.timeoutFlag), 32'h0);
        end
        check("t4_tflag_set", 32'(if1.timeoutFlag), 32'h1);
        @(negedge clock);
        if1.slaveDone = 4'b0100;
        if1.slaveResult[95:64] = 32'h55;
        if1.ciN = 8'h02;
        if1.start = 1'b1;
        q1.push_back('{res: 32'h55, at: cyc + 2});
        @(negedge clock);
        if1.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        if1.slaveDone = 4'b0000;
        check("t4_tflag_sticky", 32'(if1.timeoutFlag), 32'h1);

        // Unmatched ciN is dropped; the FSM stays ready for the next start.
        if0.ciN = 8'h7F;
        if0.start = 1'b1;
        @(negedge clock);
        if0.start = 1'b0;
        check("t5_nomatch_sstart", 32'(if0.slaveStart), 32'h0);
        @(negedge clock);
        check("t5_nomatch_done", 32'(if0.done), 32'h0);
        if0.slaveDone = 4'b0001;
        if0.slaveResult[31:0] = 32'h0A0A;
        if0.ciN = 8'h00;
        if0.start = 1'b1;
        q0.push_back('{res: 32'h0A0A, at: cyc + 2});
        @(negedge clock);
        if0.start = 1'b0;
        check("t5_slave0_sstart", 32'(if0.slaveStart), 32'h1);
        @(negedge clock);
        @(negedge clock);
        if0.slaveDone = 4'b0000;

        // Aliased IDs: lowest index takes the instruction.
        if1.slaveDone = 4'b0011;
        if1.slaveResult = {32'h0, 32'h0, 32'h2222, 32'h1111};
        if1.ciN = 8'h05;
        if1.start = 1'b1;
        q1.push_back('{res: 32'h1111, at: cyc + 2});
        @(negedge clock);
        if1.start = 1'b0;
        check("t5_alias_sstart", 32'(if1.slaveStart), 32'h1);
        @(negedge clock);
        @(negedge clock);
        if1.slaveDone = 4'b0000;

        // Reset mid-WAIT aborts the transaction without a late done.
        if0.valueA = 32'h77;
        if0.ciN = 8'h01;
        if0.start = 1'b1;
        @(negedge clock);
        if0.start = 1'b0;
        check("t6_sstart", 32'(if0.slaveStart), 32'h2);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_rst_sstart", 32'(if0.slaveStart), 32'h0);
        check("t6_rst_sva", if0.slaveValueA, 32'h0);
        check("t6_rst_done", 32'(if0.done), 32'h0);
        check("t6_rst_result", if0.result, 32'h0);
        check("t6_rst_tflag", 32'(if1.timeoutFlag), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        if0.slaveDone = 4'b0010;
        repeat (4) @(negedge clock);
        if0.slaveDone = 4'b0000;
        @(negedge clock);

        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
